// File: rtl/foc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : foc_pkg
// Description : Shared types for the FOC command dispatcher: opcode classes,
//               dispatcher FSM states, pending-slot control word and the
//               opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package foc_pkg;

    typedef enum logic [3:0] {
        CMD_SET_GAINS = 4'h0,
        CMD_CLEAR     = 4'h1,
        CMD_RUN       = 4'hF
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        LAUNCH = 2'd2
    } state_e;

    // Control half of a pending run entry; the payload width depends on the
    // dispatcher parameters and is attached there.
    typedef struct packed {
        logic       full;
        logic [3:0] ch;
    } pend_ctl_t;

    // An opcode is usable only for a known class addressing an existing core.
    function automatic logic op_legal(input logic [7:0] op, input int n_ch);
        logic cls_ok;
        cls_ok = (op[7:4] == CMD_SET_GAINS) || (op[7:4] == CMD_CLEAR) ||
                 (op[7:4] == CMD_RUN);
        return cls_ok && ({28'd0, op[3:0]} < n_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/foc_cmd_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : foc_cmd_dispatcher_if
// Description : Packet-in / core-launch bundle of the FOC command dispatcher.
//               master = packet source and cores, slave = dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface foc_cmd_dispatcher_if #(
    parameter int D_WIDTH = 16,
    parameter int N_WORDS = 5,
    parameter int N_CH    = 2
);
    logic                         pkt_valid;
    logic [7:0]                   pkt_opcode;
    logic [N_WORDS*D_WIDTH-1:0]   pkt_data;
    logic [N_CH-1:0]              core_ready;
    logic [N_CH-1:0]              core_valid;
    logic [N_CH-1:0]              core_abort;
    logic [N_WORDS*D_WIDTH-1:0]   core_words;

    modport master (
        output pkt_valid, pkt_opcode, pkt_data, core_ready,
        input  core_valid, core_abort, core_words
    );

    modport slave (
        input  pkt_valid, pkt_opcode, pkt_data, core_ready,
        output core_valid, core_abort, core_words
    );
endinterface
`default_nettype wire

// File: rtl/foc_gain_bank.sv
`default_nettype none
// ============================================================================
// Module      : foc_gain_bank
// Description : Per-channel gain registers (kpd/kpq/kid/kiq/ptop) with a
//               one-cycle PID-integrator clear pulse per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module foc_gain_bank #(
    parameter int D_WIDTH = 16,
    parameter int N_WORDS = 5,
    parameter int N_CH    = 2
) (
    input  wire logic                       clk_sys,
    input  wire logic                       rst,
    input  wire logic                       wr_en,
    input  wire logic                       clr_en,
    input  wire logic [3:0]                 ch,
    input  wire logic [N_WORDS*D_WIDTH-1:0] words,
    output logic [N_CH*D_WIDTH-1:0]         kpd,
    output logic [N_CH*D_WIDTH-1:0]         kpq,
    output logic [N_CH*D_WIDTH-1:0]         kid,
    output logic [N_CH*D_WIDTH-1:0]         kiq,
    output logic [N_CH*D_WIDTH-1:0]         ptop,
    output logic [N_CH-1:0]                 clear_pid
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic               w_sel;
        logic [D_WIDTH-1:0] kpd_q, kpd_d, kpq_q, kpq_d, kid_q, kid_d;
        logic [D_WIDTH-1:0] kiq_q, kiq_d, ptop_q, ptop_d;
        logic               clr_q, clr_d;

        assign w_sel = (ch == 4'(c));

        // Next-state of this channel's gains; clear pulses on every gain write too.
        always_comb begin
            kpd_d  = kpd_q;
            kpq_d  = kpq_q;
            kid_d  = kid_q;
            kiq_d  = kiq_q;
            ptop_d = ptop_q;
            clr_d  = clr_en && w_sel;
            if (wr_en && w_sel) begin
                kpd_d  = words[4*D_WIDTH +: D_WIDTH];
                kpq_d  = words[3*D_WIDTH +: D_WIDTH];
                kid_d  = words[2*D_WIDTH +: D_WIDTH];
                kiq_d  = words[1*D_WIDTH +: D_WIDTH];
                ptop_d = words[0*D_WIDTH +: D_WIDTH];
            end
        end

        // Channel register bank.
        always_ff @(posedge clk_sys or posedge rst) begin
            if (rst) begin
                kpd_q  <= '0;
                kpq_q  <= '0;
                kid_q  <= '0;
                kiq_q  <= '0;
                ptop_q <= '0;
                clr_q  <= 1'b0;
            end else begin
                kpd_q  <= kpd_d;
                kpq_q  <= kpq_d;
                kid_q  <= kid_d;
                kiq_q  <= kiq_d;
                ptop_q <= ptop_d;
                clr_q  <= clr_d;
            end
        end

        assign kpd [c*D_WIDTH +: D_WIDTH] = kpd_q;
        assign kpq [c*D_WIDTH +: D_WIDTH] = kpq_q;
        assign kid [c*D_WIDTH +: D_WIDTH] = kid_q;
        assign kiq [c*D_WIDTH +: D_WIDTH] = kiq_q;
        assign ptop[c*D_WIDTH +: D_WIDTH] = ptop_q;
        assign clear_pid[c]               = clr_q;
    end

endmodule
`default_nettype wire

// File: rtl/foc_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : foc_cmd_dispatcher
// Description : Decodes SPI packets into gain writes, PID clears and run
//               launches for N_CH FOC cores; one-deep pending run slot,
//               per-run watchdog, sticky timeout flag, saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module foc_cmd_dispatcher
    import foc_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int N_WORDS = 5,
    parameter int N_CH    = 2,
    parameter int TIMEOUT = 4096
) (
    input  wire logic               clk_sys,
    input  wire logic               rst,
    foc_cmd_dispatcher_if.slave     bus,
    input  wire logic               status_clr,
    output logic [N_CH*D_WIDTH-1:0] kpd,
    output logic [N_CH*D_WIDTH-1:0] kpq,
    output logic [N_CH*D_WIDTH-1:0] kid,
    output logic [N_CH*D_WIDTH-1:0] kiq,
    output logic [N_CH*D_WIDTH-1:0] ptop,
    output logic [N_CH-1:0]         clear_pid,
    output logic                    ready,
    output logic [3:0]              busy_ch,
    output logic                    timeout_flag,
    output logic [7:0]              drop_cnt,
    output logic [7:0]              bad_op_cnt
);

    localparam int PKT_W = N_WORDS * D_WIDTH;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        pend_ctl_t          ctl;
        logic [PKT_W-1:0]   words;
    } pend_t;

    function automatic logic [N_CH-1:0] ch_onehot(input logic [3:0] ch);
        logic [N_CH-1:0] oh;
        for (int c = 0; c < N_CH; c++) oh[c] = (ch == 4'(c));
        return oh;
    endfunction

    state_e           state_q, state_d;
    pend_t            pend_q, pend_d;
    logic [3:0]       busy_q, busy_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [N_CH-1:0]  core_valid_q, core_valid_d;
    logic [N_CH-1:0]  core_abort_q, core_abort_d;
    logic [PKT_W-1:0] core_words_q, core_words_d;
    logic             tflag_q, tflag_d;
    logic [7:0]       drop_q, drop_d, bad_q, bad_d;

    logic [3:0] w_cls, w_ch;
    logic       w_legal, w_bad, w_run, w_gain_wr, w_pid_clr;
    logic       w_done, w_abort, w_store, w_drop_run;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum, w_bad_sum;

    // Packet decode and run-request arbitration against the current state.
    always_comb begin
        w_cls      = bus.pkt_opcode[7:4];
        w_ch       = bus.pkt_opcode[3:0];
        w_legal    = bus.pkt_valid && op_legal(bus.pkt_opcode, N_CH);
        w_bad      = bus.pkt_valid && !w_legal;
        w_run      = w_legal && (w_cls == CMD_RUN);
        w_gain_wr  = w_legal && (w_cls == CMD_SET_GAINS);
        w_pid_clr  = w_legal && ((w_cls == CMD_SET_GAINS) || (w_cls == CMD_CLEAR));
        // Completion beats expiry when both land in the same cycle.
        w_done     = (state_q == WAIT) && (|(bus.core_ready & ch_onehot(busy_q)));
        w_abort    = (state_q == WAIT) && !w_done && (wdog_q == WD_LAST);
        // The slot accepts a request when empty in WAIT, or while it drains in LAUNCH.
        w_store    = w_run && (((state_q == WAIT) && !pend_q.ctl.full && !w_abort) ||
                               (state_q == LAUNCH));
        w_drop_run = w_run && (state_q != IDLE) && !w_store;
        w_drop_inc = {1'b0, w_drop_run} + {1'b0, w_abort && pend_q.ctl.full};
    end

    // FSM next state, launches, watchdog and status bookkeeping.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        busy_d       = busy_q;
        wdog_d       = wdog_q;
        core_valid_d = '0;
        core_abort_d = '0;
        core_words_d = core_words_q;
        tflag_d      = tflag_q;

        case (state_q)
            IDLE: begin
                if (w_run) begin
                    core_valid_d = ch_onehot(w_ch);
                    core_words_d = bus.pkt_data;
                    busy_d       = w_ch;
                    wdog_d       = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (w_done) begin
                    if (pend_q.ctl.full || w_store) begin
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                        busy_d  = '0;
                    end
                end else if (w_abort) begin
                    core_abort_d    = ch_onehot(busy_q);
                    tflag_d         = 1'b1;
                    pend_d.ctl.full = 1'b0;
                    busy_d          = '0;
                    state_d         = IDLE;
                end
            end
            LAUNCH: begin
                core_valid_d    = ch_onehot(pend_q.ctl.ch);
                core_words_d    = pend_q.words;
                busy_d          = pend_q.ctl.ch;
                wdog_d          = '0;
                pend_d.ctl.full = 1'b0;
                state_d         = WAIT;
            end
            default: state_d = IDLE;
        endcase

        if (w_store) begin
            pend_d.ctl.full = 1'b1;
            pend_d.ctl.ch   = w_ch;
            pend_d.words    = bus.pkt_data;
        end

        w_drop_sum = {1'b0, drop_q} + {7'd0, w_drop_inc};
        w_bad_sum  = {1'b0, bad_q} + {8'd0, w_bad};
        drop_d     = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        bad_d      = w_bad_sum[8]  ? 8'hFF : w_bad_sum[7:0];
        if (status_clr) begin
            tflag_d = 1'b0;
            drop_d  = '0;
            bad_d   = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            busy_q       <= '0;
            wdog_q       <= '0;
            core_valid_q <= '0;
            core_abort_q <= '0;
            core_words_q <= '0;
            tflag_q      <= 1'b0;
            drop_q       <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            busy_q       <= busy_d;
            wdog_q       <= wdog_d;
            core_valid_q <= core_valid_d;
            core_abort_q <= core_abort_d;
            core_words_q <= core_words_d;
            tflag_q      <= tflag_d;
            drop_q       <= drop_d;
            bad_q        <= bad_d;
        end
    end

    foc_gain_bank #(
        .D_WIDTH (D_WIDTH),
        .N_WORDS (N_WORDS),
        .N_CH    (N_CH)
    ) u_gain_bank (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .wr_en     (w_gain_wr),
        .clr_en    (w_pid_clr),
        .ch        (w_ch),
        .words     (bus.pkt_data),
        .kpd       (kpd),
        .kpq       (kpq),
        .kid       (kid),
        .kiq       (kiq),
        .ptop      (ptop),
        .clear_pid (clear_pid)
    );

    assign bus.core_valid = core_valid_q;
    assign bus.core_abort = core_abort_q;
    assign bus.core_words = core_words_q;
    assign ready          = (state_q == IDLE) && !pend_q.ctl.full;
    assign busy_ch        = busy_q;
    assign timeout_flag   = tflag_q;
    assign drop_cnt       = drop_q;
    assign bad_op_cnt     = bad_q;

endmodule
`default_nettype wire
